// File: rtl/relay_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : relay_frame_rx_pkg
// Purpose  : Relay simulate-mode codes, framer state encoding and a small
//            helper shared by the relay receive front end.
// Revision : 1.0 - initial release
// ============================================================================
package relay_frame_rx_pkg;

    // Relay simulate-mode codes carried on hi_simulate_mod_type.
    localparam logic [2:0] c_TAGSIM_LISTEN = 3'd0;
    localparam logic [2:0] c_TAGSIM_MOD    = 3'd1;
    localparam logic [2:0] c_READER_LISTEN = 3'd2;
    localparam logic [2:0] c_READER_MOD    = 3'd3;
    localparam logic [2:0] c_FAKE_READER   = 3'd4;
    localparam logic [2:0] c_FAKE_TAG      = 3'd5;

    // Framer states.
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_STOP = 2'd2
    } rx_state_t;

    // The test pattern only advances while one of the fake endpoints is active.
    function automatic logic is_fake_mode(input logic [2:0] mode);
        return (mode == c_FAKE_READER) || (mode == c_FAKE_TAG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/relay_sym_fifo.sv
`default_nettype none
// ============================================================================
// Module   : relay_sym_fifo
// Purpose  : First-word fall-through symbol FIFO, depth 2^AW. A push into a
//            full FIFO is accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module relay_sym_fifo #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [AW:0]      level_o,
    output logic             full_o
);

    localparam int         c_DEPTH     = 1 << AW;
    localparam logic [AW:0] c_DEPTH_LVL = (AW+1)'(c_DEPTH);

    logic [WIDTH-1:0] mem_q [c_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      w_level;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic             w_push_ok;

    // Occupancy is the free-running pointer difference; the extra MSB
    // distinguishes full from empty.
    assign w_level   = wr_ptr_q - rd_ptr_q;
    assign w_full    = (w_level == c_DEPTH_LVL);
    assign w_valid   = (w_level != '0);
    assign w_pop     = w_valid & ready_i;
    assign w_push_ok = push_i & (~w_full | w_pop);

    // Pointer next-state: clear empties the FIFO regardless of push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; at full with a pop the write lands in the slot being read.
    always_ff @(posedge clk) begin
        if (!clear_i && w_push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Head word is forced to zero while empty so the output is defined.
    assign data_o  = w_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign valid_o = w_valid;
    assign level_o = w_level;
    assign full_o  = w_full;

endmodule
`default_nettype wire

// File: rtl/relay_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : relay_frame_rx
// Purpose  : Relay line receiver. Picks the live line or a rotating test
//            pattern, samples it on a divided tick, frames start/data/stop
//            symbols and buffers decoded symbols in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module relay_frame_rx
    import relay_frame_rx_pkg::*;
#(
    parameter int                 DIV_BITS  = 4,
    parameter int                 SYM_WIDTH = 4,
    parameter int                 PAT_LEN   = 180,
    parameter logic [PAT_LEN-1:0] PAT_INIT  = 180'h00f0f00f00f00f000f,
    parameter int                 FIFO_AW   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic [2:0]           hi_simulate_mod_type,
    input  logic                 test_mode,
    input  logic                 clear,
    output logic [SYM_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIFO_AW:0]     level,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int                  c_CNT_W   = $clog2(SYM_WIDTH + 1);
    localparam logic [DIV_BITS-1:0] c_TICK_AT = DIV_BITS'(1) << (DIV_BITS - 1);
    localparam logic [c_CNT_W-1:0]  c_LAST    = c_CNT_W'(SYM_WIDTH - 1);

    logic [DIV_BITS-1:0]  div_q;
    logic [PAT_LEN-1:0]   pat_q, pat_d;
    logic [1:0]           sync_q;
    rx_state_t            state_q, state_d;
    logic [c_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SYM_WIDTH-1:0] sym_q, sym_d;
    logic                 push_q, push_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;

    logic                 w_tick;
    logic                 w_src;
    logic                 w_full;
    logic                 w_valid;
    logic                 w_pop;

    assign w_tick = (div_q == c_TICK_AT);
    assign w_src  = test_mode ? pat_q[PAT_LEN-1] : sync_q[1];
    assign w_pop  = w_valid & out_ready;

    // Free-running sample divider and line synchroniser; clear leaves both alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            sync_q <= '0;
        end else begin
            div_q  <= div_q + 1'b1;
            sync_q <= {sync_q[0], data_in};
        end
    end

    // Test pattern: reload on clear, rotate left on tick in a fake mode.
    always_comb begin
        pat_d = pat_q;
        if (clear) begin
            pat_d = PAT_INIT;
        end else if (w_tick && test_mode && is_fake_mode(hi_simulate_mod_type)) begin
            pat_d = {pat_q[PAT_LEN-2:0], pat_q[PAT_LEN-1]};
        end
    end

    // Framer next-state; push and frame_err are raised for the cycle after STOP.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sym_d     = sym_q;
        push_d    = 1'b0;
        err_d     = 1'b0;
        if (clear) begin
            state_d   = RX_IDLE;
            bit_cnt_d = '0;
        end else if (w_tick) begin
            case (state_q)
                RX_IDLE: begin
                    if (w_src) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    sym_d     = (sym_q << 1) | SYM_WIDTH'(w_src);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == c_LAST) begin
                        state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_src) begin
                        err_d = 1'b1;
                    end else begin
                        push_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // Sticky overflow: a push was refused because the FIFO was full.
    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (push_q && w_full && !w_pop) begin
            ovf_d = 1'b1;
        end
    end

    // Framer, pattern and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q     <= PAT_INIT;
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            sym_q     <= '0;
            push_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sym_q     <= sym_d;
            push_q    <= push_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    // sym_q is held in IDLE, so it is still the completed symbol when push_q is high.
    relay_sym_fifo #(
        .WIDTH (SYM_WIDTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .push_i      (push_q),
        .push_data_i (sym_q),
        .ready_i     (out_ready),
        .data_o      (out_data),
        .valid_o     (w_valid),
        .level_o     (level),
        .full_o      (w_full)
    );

    assign out_valid = w_valid;
    assign overflow  = ovf_q;
    assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_relay_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_relay_frame_rx
// Purpose  : Self-checking bench for relay_frame_rx: a tick-level frame model
//            with a queue-based FIFO is compared every cycle, plus directed
//            literal checks for each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relay_frame_rx;
    import relay_frame_rx_pkg::*;

    localparam int                 DIV_BITS  = 4;
    localparam int                 SYM_WIDTH = 4;
    localparam int                 PAT_LEN   = 12;
    localparam logic [PAT_LEN-1:0] PAT_INIT  = 12'hD40;
    localparam int                 FIFO_AW   = 3;
    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam int                 PERIOD    = 1 << DIV_BITS;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 data_in   = 1'b0;
    logic [2:0]           mode      = c_READER_LISTEN;
    logic                 test_mode = 1'b0;
    logic                 clear     = 1'b0;
    logic                 out_ready = 1'b0;
    logic [SYM_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic [FIFO_AW:0]     level;
    logic                 overflow;
    logic                 frame_err;

    relay_frame_rx #(
        .DIV_BITS  (DIV_BITS),
        .SYM_WIDTH (SYM_WIDTH),
        .PAT_LEN   (PAT_LEN),
        .PAT_INIT  (PAT_INIT),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .data_in              (data_in),
        .hi_simulate_mod_type (mode),
        .test_mode            (test_mode),
        .clear                (clear),
        .out_data             (out_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .level                (level),
        .overflow             (overflow),
        .frame_err            (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PAT_LEN-1:0]   m_pat      = PAT_INIT;
    int                   m_cnt      = 0;
    bit                   m_tick     = 0;
    int                   m_pat_idx  = 0;
    bit                   m_h1       = 0;
    bit                   m_h2       = 0;
    int                   m_frm[$];
    bit                   m_push_pend = 0;
    logic [SYM_WIDTH-1:0] m_push_sym = '0;
    bit                   m_err      = 0;
    bit                   m_ovf      = 0;
    logic [SYM_WIDTH-1:0] m_q[$];
    int                   m_err_tally = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_tick = 0; m_pat_idx = 0; m_h1 = 0; m_h2 = 0;
            m_frm.delete(); m_push_pend = 0; m_err = 0; m_ovf = 0; m_q.delete();
        end else begin : m_step
            bit src;
            bit pop;
            bit tick;
            logic [SYM_WIDTH-1:0] sym;
            src  = test_mode ? m_pat[PAT_LEN-1-m_pat_idx] : m_h2;
            tick = ((m_cnt % PERIOD) == PERIOD / 2);
            m_cnt++;
            m_h2 = m_h1;
            m_h1 = data_in;
            pop  = (m_q.size() > 0) && out_ready;
            if (clear) begin
                m_q.delete(); m_ovf = 0; m_frm.delete(); m_pat_idx = 0;
                m_push_pend = 0; m_err = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_push_pend) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_push_sym);
                    else m_ovf = 1;
                end
                m_push_pend = 0;
                m_err = 0;
                if (tick) begin
                    if (test_mode && (mode == c_FAKE_READER || mode == c_FAKE_TAG))
                        m_pat_idx = (m_pat_idx + 1) % PAT_LEN;
                    // A frame is a run of 1 start, SYM_WIDTH data and 1 stop bit.
                    if (m_frm.size() > 0 || src) m_frm.push_back(int'(src));
                    if (m_frm.size() == SYM_WIDTH + 2) begin
                        sym = '0;
                        for (int i = 1; i <= SYM_WIDTH; i++) sym = (sym << 1) | SYM_WIDTH'(m_frm[i]);
                        if (m_frm[SYM_WIDTH+1] == 0) begin
                            m_push_pend = 1;
                            m_push_sym  = sym;
                        end else begin
                            m_err = 1;
                            m_err_tally++;
                        end
                        m_frm.delete();
                    end
                end
            end
            m_tick = tick;
        end
    end

    // ---------------- per-cycle compare ----------------
    int                   dut_err_cnt = 0;
    logic [SYM_WIDTH-1:0] pop_log[$];

    always @(negedge clk) begin
        logic [SYM_WIDTH-1:0] exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : '0;
        check("cyc_valid",    32'(out_valid), 32'(m_q.size() > 0));
        check("cyc_data",     32'(out_data),  32'(exp_data));
        check("cyc_level",    32'(level),     32'(m_q.size()));
        check("cyc_overflow", 32'(overflow),  32'(m_ovf));
        check("cyc_frameerr", 32'(frame_err), 32'(m_err));
        if (frame_err === 1'b1) dut_err_cnt++;
        if (out_valid === 1'b1 && out_ready) pop_log.push_back(out_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!m_tick && k < 4 * PERIOD);
        if (!m_tick) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: got no tick within %0d cycles", k);
        end
    endtask

    // Must be called just after a tick; each bit is held for one tick period.
    task automatic send_frame(input logic [SYM_WIDTH-1:0] sym, input bit ready_on_push);
        data_in = 1'b1;
        wait_tick();
        for (int i = SYM_WIDTH - 1; i >= 0; i--) begin
            data_in = sym[i];
            wait_tick();
        end
        data_in = 1'b0;
        wait_tick();
        if (ready_on_push) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        step();
        check("rst_valid",    32'(out_valid), 0);
        check("rst_data",     32'(out_data),  0);
        check("rst_level",    32'(level),     0);
        check("rst_overflow", 32'(overflow),  0);
        check("rst_frameerr", 32'(frame_err), 0);
        step();
        reset = 1'b0;

        // Live frame 1,1010,0 decodes to A.
        wait_tick();
        send_frame(4'hA, 0);
        check("live_not_early", 32'(out_valid), 0);
        step();
        check("live_valid", 32'(out_valid), 1);
        check("live_data",  32'(out_data),  32'hA);
        check("live_level", 32'(level),     1);
        check("live_err",   32'(dut_err_cnt), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("live_popped", 32'(level), 0);

        // Overflow: nine frames into an eight-deep FIFO.
        pulse_clear();
        wait_tick();
        for (int s = 1; s <= 9; s++) send_frame(SYM_WIDTH'(s), 0);
        step(); step();
        check("ovf_level", 32'(level),    8);
        check("ovf_flag",  32'(overflow), 1);
        pop_log.delete();
        out_ready = 1'b1;
        repeat (12) step();
        out_ready = 1'b0;
        check("ovf_pop_count", 32'(pop_log.size()), 8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            check("ovf_pop_order", 32'(pop_log[i]), 32'(i + 1));
        check("ovf_sticky", 32'(overflow), 1);
        pulse_clear();
        check("ovf_cleared", 32'(overflow), 0);

        // Push and pop together at full.
        wait_tick();
        for (int s = 1; s <= 8; s++) send_frame(SYM_WIDTH'(s), 0);
        send_frame(4'h9, 1);
        check("pp_level", 32'(level),    8);
        check("pp_ovf",   32'(overflow), 0);
        check("pp_head",  32'(out_data), 2);
        pop_log.delete();
        out_ready = 1'b1;
        repeat (12) step();
        out_ready = 1'b0;
        check("pp_pop_count", 32'(pop_log.size()), 8);
        if (pop_log.size() == 8) check("pp_last", 32'(pop_log[7]), 9);

        // Asynchronous reset after two data bits.
        send_frame(4'h6, 0);
        step();
        data_in = 1'b1; wait_tick();
        data_in = 1'b1; wait_tick();
        data_in = 1'b0; wait_tick();
        #2 reset = 1'b1;
        #1;
        check("amid_level", 32'(level),     0);
        check("amid_valid", 32'(out_valid), 0);
        step();
        reset = 1'b0;
        wait_tick();
        send_frame(4'h5, 0);
        step();
        check("amid_data",  32'(out_data), 5);
        check("amid_level2", 32'(level),   1);

        // Synchronous clear after two data bits.
        data_in = 1'b1; wait_tick();
        data_in = 1'b0; wait_tick();
        data_in = 1'b1; wait_tick();
        data_in = 1'b0;
        pulse_clear();
        check("cmid_level", 32'(level),    0);
        check("cmid_ovf",   32'(overflow), 0);
        wait_tick();
        send_frame(4'hC, 0);
        step();
        check("cmid_data",  32'(out_data), 32'hC);
        check("cmid_level2", 32'(level),   1);

        // Pattern D40 in FAKE_TAG: 1,1010,1 repeats every 12 ticks -> two bad stops in 24 ticks.
        out_ready = 1'b1;
        mode      = c_FAKE_TAG;
        test_mode = 1'b1;
        pulse_clear();
        dut_err_cnt = 0;
        m_err_tally = 0;
        repeat (24) wait_tick();
        step(); step();
        check("pat_errs",       32'(dut_err_cnt), 2);
        check("pat_model_errs", 32'(m_err_tally), 2);
        check("pat_level",      32'(level),       0);

        // TAGSIM_MOD freezes the pattern (MSB=1): a bad stop every 6 ticks.
        mode = c_TAGSIM_MOD;
        pulse_clear();
        dut_err_cnt = 0;
        m_err_tally = 0;
        repeat (24) wait_tick();
        step(); step();
        check("gate_errs",       32'(dut_err_cnt), 4);
        check("gate_model_errs", 32'(m_err_tally), 4);
        check("gate_level",      32'(level),       0);

        // Drop to the live line mid-frame; the framer must recover.
        repeat (2) wait_tick();
        test_mode = 1'b0;
        data_in   = 1'b0;
        repeat (SYM_WIDTH + 4) wait_tick();
        pop_log.delete();
        send_frame(4'h3, 0);
        repeat (3) step();
        check("switch_count", 32'(pop_log.size()), 1);
        if (pop_log.size() > 0) check("switch_data", 32'(pop_log[0]), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
